// File: rtl/digit_collector.sv
// digit_collector: receive end of the 12-slot keypad scan link.
// Samples Din once per slot, assembles a 12-bit frame, debounces whole
// frames and reports newly pressed keys as a 4-bit code with a strobe.
//
// Handshake: KEY_VALID and SYNC_ERR are one-cycle strobes with no ready;
// KEY_CODE is held from one KEY_VALID strobe to the next.
module digit_collector #(
  parameter int SLOT_CYCLES  = 20,
  parameter int SAMPLE_PHASE = 10,
  parameter int DEB_FRAMES   = 3,
  parameter int ACTIVE_HIGH  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Din,
  input  logic        FRAME,
  output logic [11:0] KEYS,
  output logic        KEY_VALID,
  output logic [3:0]  KEY_CODE,
  output logic        MULTI,
  output logic        SYNC_ERR,
  output logic        state_dbg
);

  localparam int PW = $clog2(SLOT_CYCLES);
  localparam int CW = $clog2(DEB_FRAMES + 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t        state;
  logic [3:0]    slot;
  logic [PW-1:0] phase;
  logic [11:0]   shift;
  logic [11:0]   cand;
  logic [CW-1:0] cnt;

  logic          key_bit;
  logic          at_origin;
  logic          last_cycle;
  logic          restart;
  logic          sync_hit;
  logic [3:0]    cur_slot;
  logic [PW-1:0] cur_phase;
  logic [11:0]   shift_next;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic [11:0]   new_bits;
  logic [3:0]    low_slot;
  logic [3:0]    low_code;

  assign state_dbg = state;

  // Slot position decode, resync detection and the frame with this cycle's sample merged in
  always_comb begin
    key_bit    = (ACTIVE_HIGH != 0) ? Din : ~Din;
    at_origin  = (slot == 4'd0) && (phase == '0);
    last_cycle = (state == SCAN) && (slot == 4'd11) && (phase == PW'(SLOT_CYCLES - 1));
    // A FRAME on the completing cycle is ignored; elsewhere in SCAN it aborts the frame
    sync_hit   = FRAME && (state == SCAN) && !at_origin && !last_cycle;
    restart    = FRAME && ((state == IDLE) || sync_hit);
    cur_slot   = restart ? 4'd0 : slot;
    cur_phase  = restart ? '0 : phase;
    shift_next = restart ? 12'd0 : shift;
    if ((restart || (state == SCAN)) && (cur_phase == PW'(SAMPLE_PHASE)))
      shift_next[cur_slot] = key_bit;
  end

  // Debounce count and press detection for the frame completing this cycle
  always_comb begin
    if (shift_next == cand)
      cnt_next = (cnt == CW'(DEB_FRAMES)) ? cnt : cnt + CW'(1);
    else
      cnt_next = CW'(1);
    accept   = (cnt_next == CW'(DEB_FRAMES));
    new_bits = shift_next & ~KEYS;
    low_slot = 4'd0;
    for (int i = 11; i >= 0; i--)
      if (new_bits[i]) low_slot = 4'(i);
    case (low_slot)
      4'd9:    low_code = 4'd10;
      4'd10:   low_code = 4'd0;
      4'd11:   low_code = 4'd11;
      default: low_code = low_slot + 4'd1;
    endcase
  end

  // More than one key held in the debounced vector
  always_comb begin
    MULTI = (KEYS & (KEYS - 12'd1)) != 12'd0;
  end

  // Scan FSM, frame assembly, debounce state and registered strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      slot      <= 4'd0;
      phase     <= '0;
      shift     <= 12'd0;
      cand      <= 12'd0;
      cnt       <= '0;
      KEYS      <= 12'd0;
      KEY_VALID <= 1'b0;
      KEY_CODE  <= 4'd0;
      SYNC_ERR  <= 1'b0;
    end else begin
      KEY_VALID <= 1'b0;
      SYNC_ERR  <= sync_hit;
      if (restart) begin
        // The FRAME cycle itself is phase 0 of slot 0
        state <= SCAN;
        slot  <= 4'd0;
        phase <= PW'(1);
        shift <= shift_next;
      end else if (state == SCAN) begin
        if (last_cycle) begin
          state <= IDLE;
          slot  <= 4'd0;
          phase <= '0;
          shift <= 12'd0;
          cand  <= shift_next;
          cnt   <= cnt_next;
          if (accept) begin
            KEYS <= shift_next;
            if (new_bits != 12'd0) begin
              KEY_VALID <= 1'b1;
              KEY_CODE  <= low_code;
            end
          end
        end else begin
          shift <= shift_next;
          if (phase == PW'(SLOT_CYCLES - 1)) begin
            phase <= '0;
            slot  <= slot + 4'd1;
          end else begin
            phase <= phase + PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_collector.sv
// Bench for digit_collector: two builds share the serial line, one with
// default parameters and one with DEB_FRAMES=1 / ACTIVE_HIGH=0. A
// frame-level reference model predicts KEYS, strobes and codes.
module tb_digit_collector;

  localparam int SLOT = 20;
  localparam int FLEN = 12 * SLOT;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic Din = 1'b0;
  logic FRAME = 1'b0;
  always #5 CLK = ~CLK;

  logic [11:0] keys [2];
  logic        valid [2];
  logic [3:0]  code [2];
  logic        multi [2];
  logic        sync [2];
  logic        st [2];

  digit_collector dut_a (
    .CLK(CLK), .RST(RST), .Din(Din), .FRAME(FRAME),
    .KEYS(keys[0]), .KEY_VALID(valid[0]), .KEY_CODE(code[0]),
    .MULTI(multi[0]), .SYNC_ERR(sync[0]), .state_dbg(st[0])
  );

  digit_collector #(.DEB_FRAMES(1), .ACTIVE_HIGH(0)) dut_b (
    .CLK(CLK), .RST(RST), .Din(Din), .FRAME(FRAME),
    .KEYS(keys[1]), .KEY_VALID(valid[1]), .KEY_CODE(code[1]),
    .MULTI(multi[1]), .SYNC_ERR(sync[1]), .state_dbg(st[1])
  );

  // ---------------- reference model ----------------
  int          deb [2] = '{3, 1};
  bit          ah [2]  = '{1'b1, 1'b0};
  int          code_tbl [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
  logic [11:0] m_prev [2];
  logic [11:0] m_keys [2];
  int          m_cnt [2];
  logic [3:0]  m_code [2];
  logic        m_valid [2];
  int          m_strobes [2];
  int          m_syncs;
  int          strobes [2];
  int          syncs [2];
  bit          pending;
  bit          abort_flag;

  int total = 0;
  int bad = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev[d]  = 12'd0;
      m_keys[d]  = 12'd0;
      m_cnt[d]   = 0;
      m_code[d]  = 4'd0;
      m_valid[d] = 1'b0;
    end
    pending    = 1'b0;
    abort_flag = 1'b0;
  endtask

  // One complete frame whose Din level per slot is v[slot]
  task automatic model_frame(input logic [11:0] v);
    logic [11:0] f, nw;
    for (int d = 0; d < 2; d++) begin
      f = ah[d] ? v : ~v;
      if (f == m_prev[d]) m_cnt[d] = (m_cnt[d] + 1 > deb[d]) ? deb[d] : m_cnt[d] + 1;
      else m_cnt[d] = 1;
      m_prev[d]  = f;
      m_valid[d] = 1'b0;
      if (m_cnt[d] == deb[d]) begin
        nw = f & ~m_keys[d];
        if (nw != 12'd0) begin
          for (int s = 11; s >= 0; s--)
            if (nw[s]) m_code[d] = 4'(code_tbl[s]);
          m_valid[d] = 1'b1;
          m_strobes[d]++;
        end
        m_keys[d] = f;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s keys[%0d]", where, d), 32'(keys[d]), 32'(m_keys[d]));
      chk($sformatf("%s valid[%0d]", where, d), 32'(valid[d]), 32'(m_valid[d]));
      chk($sformatf("%s code[%0d]", where, d), 32'(code[d]), 32'(m_code[d]));
      chk($sformatf("%s multi[%0d]", where, d), 32'(multi[d]), 32'($countones(m_keys[d]) > 1));
      chk($sformatf("%s state[%0d]", where, d), 32'(st[d]), 32'(0));
    end
  endtask

  // Strobe monitors
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (valid[d] === 1'b1) strobes[d]++;
      if (sync[d] === 1'b1) syncs[d]++;
    end
  end

  // ---------------- driver tasks ----------------
  // Drives a frame of len cycles (FLEN = complete; shorter = aborted by the next FRAME)
  task automatic send_frame(input logic [11:0] v, input int len, input string tag);
    for (int i = 0; i < len; i++) begin
      @(posedge CLK); #1;
      FRAME = (i == 0);
      Din   = v[i / SLOT];
      if (i == 0 && pending) begin
        check_outputs(tag);
        pending = 1'b0;
      end
      if (i == 1) begin
        for (int d = 0; d < 2; d++)
          chk($sformatf("%s sync[%0d]", tag, d), 32'(sync[d]), 32'(abort_flag));
        abort_flag = 1'b0;
      end
    end
    if (len == FLEN) begin
      model_frame(v);
      pending = 1'b1;
    end else begin
      abort_flag = 1'b1;
      m_syncs++;
    end
  endtask

  task automatic flush(input string tag);
    @(posedge CLK); #1;
    FRAME = 1'b0;
    Din   = 1'b0;
    if (pending) begin
      check_outputs(tag);
      pending = 1'b0;
    end
  endtask

  task automatic repeat_frame(input logic [11:0] v, input int n, input string tag);
    for (int k = 0; k < n; k++) send_frame(v, FLEN, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] rv;
    int          reps;
    for (int d = 0; d < 2; d++) begin
      m_strobes[d] = 0;
      strobes[d]   = 0;
      syncs[d]     = 0;
    end
    m_syncs = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_outputs("reset");
    for (int d = 0; d < 2; d++) chk($sformatf("reset sync[%0d]", d), 32'(sync[d]), 32'(0));
    RST = 1'b1;

    // Single press on slot 4, then a fourth identical frame
    repeat_frame(12'h010, 4, "single");

    // Asynchronous reset in the middle of a scan
    send_frame(12'h010, 100, "rst_pre");
    abort_flag = 1'b0;
    m_syncs--;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_mid");
    for (int d = 0; d < 2; d++) chk($sformatf("rst_mid sync[%0d]", d), 32'(sync[d]), 32'(0));
    repeat (3) @(posedge CLK);
    #1;
    RST   = 1'b1;
    FRAME = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      Din = 1'($urandom_range(0, 1));
    end
    check_outputs("din_only");
    for (int d = 0; d < 2; d++)
      chk($sformatf("din_only strobes[%0d]", d), 32'(strobes[d]), 32'(m_strobes[d]));

    // Glitch on slot 0 for two frames, then released
    repeat_frame(12'h001, 2, "glitch");
    repeat_frame(12'h000, 3, "glitch_rel");

    // Two keys together, then a third added
    repeat_frame(12'h600, 3, "multi");
    repeat_frame(12'hE00, 3, "multi_add");
    repeat_frame(12'h000, 3, "multi_rel");

    // Resync at slot 6 phase 3: debounce count carries across the aborted frame
    repeat_frame(12'h080, 2, "resync_a");
    send_frame(12'h080, 6 * SLOT + 3, "resync_part");
    repeat_frame(12'h080, 1, "resync_b");
    repeat_frame(12'h080, 1, "resync_c");

    // Back-to-back frames with slot 10 driven low, then all high
    repeat_frame(12'hBFF, 10, "b2b");
    repeat_frame(12'hFFF, 3, "b2b_rel");

    // Random frame groups with occasional aborted frames
    for (int g = 0; g < 14; g++) begin
      rv   = 12'($urandom_range(0, 4095)) & 12'($urandom_range(0, 4095));
      reps = $urandom_range(1, 4);
      for (int k = 0; k < reps; k++) begin
        if ($urandom_range(0, 4) == 0)
          send_frame(12'($urandom_range(0, 4095)), $urandom_range(2, FLEN - 1), "rand_part");
        send_frame(rv, FLEN, "rand");
      end
    end

    flush("final");
    repeat (4) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("strobe_count[%0d]", d), 32'(strobes[d]), 32'(m_strobes[d]));
      chk($sformatf("sync_count[%0d]", d), 32'(syncs[d]), 32'(m_syncs));
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
